wishbone_rr_arbiter: RTL and testbench
======================================

Name: wishbone_rr_arbiter

Overview:
Four-master round-robin Wishbone arbiter that shares one downstream bus port between four requesters, e.g. instruction fetch, data port, DMA and debug.
Bus ownership is decided per cycle and locked for the whole CYC; burst hints pass through to the owner's slave side.
It sits in the inner interconnect in front of the memory/peripheral crossbar.
The arbiter always forces at least one idle bus cycle between owners.

Parameters:
ADDR_W, 24, Wishbone address width.
DATA_W, 16, Wishbone data width.
TIMEOUT, 255, stall cycles before the watchdog error fires (used only with WB_ARB_WDT_EN); legal range 1..255.

Ports:
i_clk  input  1  single clock, rising edge
i_rst  input  1  synchronous active-high reset
i_cyc  input  4  per-master CYC, bit k = master k
i_stb  input  4  per-master STB
i_adr  input  4*ADDR_W  packed addresses, master k at [k*ADDR_W +: ADDR_W]
i_dat  input  4*DATA_W  packed write data
i_we  input  4  per-master write enable
i_sel  input  8  packed 2-bit byte selects
i_8_burst  input  4  per-master 8-beat burst hint
i_4_burst  input  4  per-master 4-beat burst hint
o_ack  output  4  per-master ACK
o_err  output  4  per-master ERR
o_gnt  output  4  one-hot current owner (status/debug)
o_wb_cyc  output  1  downstream CYC
o_wb_stb  output  1  downstream STB
o_wb_adr  output  ADDR_W  downstream address
o_wb_dat  output  DATA_W  downstream write data
o_wb_we  output  1  downstream WE
o_wb_sel  output  2  downstream SEL
o_wb_8_burst  output  1  downstream 8-burst hint
o_wb_4_burst  output  1  downstream 4-burst hint
i_wb_ack  input  1  downstream ACK
i_wb_err  input  1  downstream ERR

Behaviour:
- Clock and reset: one clock i_clk; reset i_rst is synchronous, active-high.
- Registered state: state in {IDLE, OWNED}, grant[1:0], last[1:0].
- Reset values: state=IDLE, grant=0, last=3 (master 0 has top priority after reset), watchdog count=0.
- All outputs are 0 during reset and in IDLE: o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat, burst hints, o_ack, o_err, o_gnt.
- IDLE: if any i_cyc bit is set, pick the first set bit searching last+1, last+2, last+3, last (mod 4). Register it into grant and go to OWNED next edge.
- Arbitration latency: i_cyc seen at edge t gives o_wb_cyc=1 after edge t+1.
- OWNED, output drive:
  - o_wb_cyc = i_cyc[grant].
  - stb/adr/dat/we/sel/burst are muxed combinationally from master grant.
  - o_ack[grant]=i_wb_ack and o_err[grant]=i_wb_err; non-owners' ack/err are 0.
  - o_gnt = one-hot(grant).
- OWNED, exit: when i_cyc[grant]=0 at an edge, set last<=grant and go to IDLE.
  - o_wb_cyc falls combinationally with the master's CYC.
  - At least one IDLE cycle separates two owners, even if other requests are pending.
- Ownership is never preempted. Other masters' requests are ignored while OWNED.
- Requests arriving or dropping during IDLE are sampled only at the decision edge; a CYC pulse that is low at that edge is lost.
- Simultaneous ack and owner CYC drop in the same cycle: the ack still routes to the owner that cycle.
- Wrap-around: after last=3 the search starts at 0.
- Combinational paths: i_* to o_wb_*, and i_wb_ack/err to o_ack/o_err; no registers on the data path.

Optional Feature:
WB_ARB_WDT_EN
- Defined:
  - An 8-bit counter increments each OWNED cycle with o_wb_stb=1, i_wb_ack=0 and i_wb_err=0.
  - It clears on ack, err, stb=0, IDLE or reset.
  - When count==TIMEOUT, o_err[grant] is forced to 1 for that cycle and the counter clears.
  - The downstream bus is unaffected; the master is expected to drop CYC.
- Undefined: no counter is built; o_err is the pure pass-through described in Behaviour.

Test Plan:
- Reset, then i_cyc=4'b0001 at edge 0 -> o_gnt=0001 and o_wb_cyc=1 after edge 1; i_wb_ack routes to o_ack[0] only.
- i_cyc=4'b1111 held with each owner dropping CYC after 2 acks -> grant order 0,1,2,3,0 with one idle cycle (o_wb_cyc=0) between each.
- Master 2 owns and is mid 8-burst; master 0 raises CYC -> grant stays 2 for all 8 acks; o_wb_8_burst=1 throughout; master 0 is granted only after master 2 drops CYC plus one idle cycle.
- i_rst pulsed while master 1 is OWNED with stb=1 -> next cycle all outputs 0, state IDLE, and the following arbitration starts at master 0.
- WB_ARB_WDT_EN, TIMEOUT=4, owner stb=1 with no ack -> o_err[owner]=1 for exactly one cycle on the 5th stalled cycle (count==4).
- WB_ARB_WDT_EN, ack on the 3rd stalled cycle -> no error, and the counter restarts at 0.

Source files
------------

// File: rtl/wishbone_rr_arbiter_if.sv
// rtl/wishbone_rr_arbiter_if.sv - four-master Wishbone request side and shared downstream port
interface wishbone_rr_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic [3:0]          i_cyc;
  logic [3:0]          i_stb;
  logic [4*ADDR_W-1:0] i_adr;
  logic [4*DATA_W-1:0] i_dat;
  logic [3:0]          i_we;
  logic [7:0]          i_sel;
  logic [3:0]          i_8_burst;
  logic [3:0]          i_4_burst;
  logic [3:0]          o_ack;
  logic [3:0]          o_err;
  logic [3:0]          o_gnt;
  logic                o_wb_cyc;
  logic                o_wb_stb;
  logic [ADDR_W-1:0]   o_wb_adr;
  logic [DATA_W-1:0]   o_wb_dat;
  logic                o_wb_we;
  logic [1:0]          o_wb_sel;
  logic                o_wb_8_burst;
  logic                o_wb_4_burst;
  logic                i_wb_ack;
  logic                i_wb_err;

  // Arbiter view
  modport slave (
    input  i_cyc, i_stb, i_adr, i_dat, i_we, i_sel, i_8_burst, i_4_burst, i_wb_ack, i_wb_err,
    output o_ack, o_err, o_gnt, o_wb_cyc, o_wb_stb, o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel,
           o_wb_8_burst, o_wb_4_burst
  );

  // Requesters plus downstream slave view
  modport master (
    output i_cyc, i_stb, i_adr, i_dat, i_we, i_sel, i_8_burst, i_4_burst, i_wb_ack, i_wb_err,
    input  o_ack, o_err, o_gnt, o_wb_cyc, o_wb_stb, o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel,
           o_wb_8_burst, o_wb_4_burst
  );
endinterface

// File: rtl/wishbone_rr_arbiter.sv
// rtl/wishbone_rr_arbiter.sv - four-master round-robin Wishbone arbiter, CYC-locked ownership
// Optional stall watchdog enabled by defining WB_ARB_WDT_EN.
module wishbone_rr_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  wishbone_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, OWNED} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       found;
  logic       owned;
  logic       wdt_fire;

  // Rotating search starting just after the previous owner
  always_comb begin
    pick  = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && bus.i_cyc[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWNED;
          grant_d = pick;
          gnt_d   = 4'b0001 << pick;
        end
      end
      OWNED: begin
        if (!bus.i_cyc[grant_q]) begin
          state_d = IDLE;
          last_d  = grant_q;
          gnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'd3;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  // Outputs are forced low while reset is held so a stale owner never leaks through
  assign owned = (state_q == OWNED) && !i_rst;

  assign bus.o_gnt        = owned ? gnt_q : 4'b0000;
  assign bus.o_wb_cyc     = owned & bus.i_cyc[grant_q];
  assign bus.o_wb_stb     = owned & bus.i_stb[grant_q];
  assign bus.o_wb_we      = owned & bus.i_we[grant_q];
  assign bus.o_wb_8_burst = owned & bus.i_8_burst[grant_q];
  assign bus.o_wb_4_burst = owned & bus.i_4_burst[grant_q];
  assign bus.o_wb_adr     = owned ? bus.i_adr[int'(grant_q)*ADDR_W +: ADDR_W] : '0;
  assign bus.o_wb_dat     = owned ? bus.i_dat[int'(grant_q)*DATA_W +: DATA_W] : '0;
  assign bus.o_wb_sel     = owned ? bus.i_sel[int'(grant_q)*2 +: 2] : 2'b00;
  assign bus.o_ack        = {4{bus.i_wb_ack}} & bus.o_gnt;
  assign bus.o_err        = {4{bus.i_wb_err | wdt_fire}} & bus.o_gnt;

`ifdef WB_ARB_WDT_EN
  logic [7:0] wdt_q, wdt_d;

  assign wdt_fire = owned && (wdt_q == 8'(TIMEOUT));

  always_comb begin
    wdt_d = wdt_q + 8'd1;
    if (!owned || wdt_fire || !bus.o_wb_stb || bus.i_wb_ack || bus.i_wb_err) begin
      wdt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  assign wdt_fire = 1'b0;
`endif
endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// tb/tb_wishbone_rr_arbiter.sv - directed self-checking bench for wishbone_rr_arbiter
module tb_wishbone_rr_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [23:0] adr_tab [4];
  logic [15:0] dat_tab [4];

  wishbone_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wishbone_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    adr_tab = '{24'h900000, 24'hA00001, 24'hB00002, 24'hC00003};
    dat_tab = '{16'h1110, 16'h2221, 16'h3332, 16'h4443};
    bus.i_adr     = {adr_tab[3], adr_tab[2], adr_tab[1], adr_tab[0]};
    bus.i_dat     = {dat_tab[3], dat_tab[2], dat_tab[1], dat_tab[0]};
    bus.i_sel     = 8'b11_10_01_11;
    bus.i_we      = 4'b0101;
    bus.i_cyc     = 4'b1111;
    bus.i_stb     = 4'b1111;
    bus.i_8_burst = 4'b0000;
    bus.i_4_burst = 4'b0000;
    bus.i_wb_ack  = 1'b1;
    bus.i_wb_err  = 1'b0;

    // Reset state: all outputs low even with requests and ack present
    step();
    step();
    settle();
    chk("rst_cyc", 32'(bus.o_wb_cyc), 32'd0);
    chk("rst_gnt", 32'(bus.o_gnt), 32'd0);
    chk("rst_stb", 32'(bus.o_wb_stb), 32'd0);
    chk("rst_adr", 32'(bus.o_wb_adr), 32'd0);
    chk("rst_ack", 32'(bus.o_ack), 32'd0);
    bus.i_wb_ack = 1'b0;
    bus.i_cyc    = 4'b0000;
    bus.i_stb    = 4'b0000;
    rst          = 1'b0;
    step();

    // Single master: one-cycle grant latency, muxed data path, ack/err routing
    bus.i_cyc = 4'b0001;
    bus.i_stb = 4'b0001;
    settle();
    chk("t1_pre_cyc", 32'(bus.o_wb_cyc), 32'd0);
    step();
    settle();
    chk("t1_gnt", 32'(bus.o_gnt), 32'h1);
    chk("t1_cyc", 32'(bus.o_wb_cyc), 32'd1);
    chk("t1_stb", 32'(bus.o_wb_stb), 32'd1);
    chk("t1_adr", 32'(bus.o_wb_adr), 32'h900000);
    chk("t1_dat", 32'(bus.o_wb_dat), 32'h1110);
    chk("t1_we", 32'(bus.o_wb_we), 32'd1);
    chk("t1_sel", 32'(bus.o_wb_sel), 32'd3);
    bus.i_wb_err = 1'b1;
    settle();
    chk("t1_err", 32'(bus.o_err), 32'h1);
    bus.i_wb_err = 1'b0;
    step();
    bus.i_wb_ack = 1'b1;
    bus.i_cyc    = 4'b0000;
    bus.i_stb    = 4'b0000;
    settle();
    chk("t1_ack_on_drop", 32'(bus.o_ack), 32'h1);
    chk("t1_cyc_drop", 32'(bus.o_wb_cyc), 32'd0);
    step();
    bus.i_wb_ack = 1'b0;
    settle();
    chk("t1_idle_gnt", 32'(bus.o_gnt), 32'd0);

    // Full contention after reset: order 0,1,2,3,0 with an idle cycle between owners
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.i_cyc = 4'b1111;
    bus.i_stb = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      settle();
      chk($sformatf("rr%0d_gnt", n), 32'(bus.o_gnt), 32'(4'b0001 << (n % 4)));
      chk($sformatf("rr%0d_adr", n), 32'(bus.o_wb_adr), 32'(adr_tab[n % 4]));
      bus.i_wb_ack = 1'b1;
      settle();
      chk($sformatf("rr%0d_ack1", n), 32'(bus.o_ack), 32'(4'b0001 << (n % 4)));
      step();
      settle();
      chk($sformatf("rr%0d_ack2", n), 32'(bus.o_ack), 32'(4'b0001 << (n % 4)));
      step();
      bus.i_wb_ack      = 1'b0;
      bus.i_cyc[n % 4]  = 1'b0;
      settle();
      chk($sformatf("rr%0d_cyc_drop", n), 32'(bus.o_wb_cyc), 32'd0);
      step();
      settle();
      chk($sformatf("rr%0d_idle_gnt", n), 32'(bus.o_gnt), 32'd0);
      chk($sformatf("rr%0d_idle_cyc", n), 32'(bus.o_wb_cyc), 32'd0);
      bus.i_cyc[n % 4] = 1'b1;
    end
    bus.i_cyc = 4'b0000;
    bus.i_stb = 4'b0000;
    step();

    // Master 2 bursts; master 0 must wait for the drop plus one idle cycle
    bus.i_cyc     = 4'b0100;
    bus.i_stb     = 4'b0100;
    bus.i_8_burst = 4'b0100;
    step();
    settle();
    chk("b_gnt", 32'(bus.o_gnt), 32'h4);
    chk("b_4burst", 32'(bus.o_wb_4_burst), 32'd0);
    bus.i_cyc    = 4'b0101;
    bus.i_stb    = 4'b0101;
    bus.i_wb_ack = 1'b1;
    for (int b = 0; b < 8; b++) begin
      settle();
      chk($sformatf("b%0d_gnt", b), 32'(bus.o_gnt), 32'h4);
      chk($sformatf("b%0d_8burst", b), 32'(bus.o_wb_8_burst), 32'd1);
      chk($sformatf("b%0d_ack", b), 32'(bus.o_ack), 32'h4);
      step();
    end
    bus.i_wb_ack  = 1'b0;
    bus.i_cyc     = 4'b0001;
    bus.i_stb     = 4'b0001;
    bus.i_8_burst = 4'b0000;
    settle();
    chk("b_cyc_drop", 32'(bus.o_wb_cyc), 32'd0);
    step();
    settle();
    chk("b_idle_gnt", 32'(bus.o_gnt), 32'd0);
    step();
    settle();
    chk("b_m0_gnt", 32'(bus.o_gnt), 32'h1);
    bus.i_cyc = 4'b0000;
    bus.i_stb = 4'b0000;
    step();

    // Reset while master 1 owns: outputs clear and priority restarts at master 0
    bus.i_cyc = 4'b0010;
    bus.i_stb = 4'b0010;
    step();
    settle();
    chk("r_gnt1", 32'(bus.o_gnt), 32'h2);
    chk("r_stb1", 32'(bus.o_wb_stb), 32'd1);
    rst = 1'b1;
    settle();
    chk("r_stb_in_rst", 32'(bus.o_wb_stb), 32'd0);
    step();
    rst       = 1'b0;
    bus.i_cyc = 4'b0011;
    bus.i_stb = 4'b0011;
    settle();
    chk("r_after_gnt", 32'(bus.o_gnt), 32'd0);
    chk("r_after_cyc", 32'(bus.o_wb_cyc), 32'd0);
    chk("r_after_stb", 32'(bus.o_wb_stb), 32'd0);
    step();
    settle();
    chk("r_regrant", 32'(bus.o_gnt), 32'h1);
    bus.i_cyc = 4'b0000;
    bus.i_stb = 4'b0000;
    step();

`ifdef WB_ARB_WDT_EN
    // TIMEOUT=4: error on the 5th stalled cycle, then an ack restarts the count
    bus.i_cyc = 4'b1000;
    bus.i_stb = 4'b1000;
    step();
    for (int c = 1; c <= 5; c++) begin
      settle();
      chk($sformatf("wdt_c%0d", c), 32'(bus.o_err), (c == 5) ? 32'h8 : 32'h0);
      step();
    end
    for (int c = 6; c <= 13; c++) begin
      bus.i_wb_ack = (c == 8);
      settle();
      chk($sformatf("wdt_c%0d", c), 32'(bus.o_err), (c == 13) ? 32'h8 : 32'h0);
      step();
    end
    bus.i_wb_ack = 1'b0;
    bus.i_cyc    = 4'b0000;
    bus.i_stb    = 4'b0000;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
